// File: rtl/regfile_pkg.sv
// Shared types and index helpers for the multi-port register file.
// Build option ZERO_REG_EN: when defined, register 0 is hardwired to zero and never busy.
package regfile_pkg;

  localparam int DEF_WORD_LENGTH = 16;
  localparam int DEF_ID_LENGTH   = 3;

`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef logic [DEF_WORD_LENGTH-1:0] word_t;
  typedef logic [DEF_ID_LENGTH-1:0]   reg_id_t;

  function automatic logic id_in_range(input int id, input int num_regs);
    return id < num_regs;
  endfunction

  // Implemented and not the hardwired zero register: may hold data and be busy.
  function automatic logic id_writable(input int id, input int num_regs);
    return id_in_range(id, num_regs) && !(ZERO_REG && id == 0);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Register file bus: writeback, N read ports, reservation handshake and occupancy.
// master = pipeline side (issue/decode/writeback), slave = register file.
interface regfile_mp_if #(
  parameter int WORD_LENGTH = 16,
  parameter int ID_LENGTH   = 3,
  parameter int NUM_REGS    = 2**ID_LENGTH,
  parameter int READ_PORTS  = 2
);
  localparam int CNT_W = $clog2(NUM_REGS + 1);

  logic                   wr_en;
  logic [ID_LENGTH-1:0]   wr_id;
  logic [WORD_LENGTH-1:0] wr_data;

  logic [ID_LENGTH-1:0]   rd_id   [READ_PORTS];
  logic [WORD_LENGTH-1:0] rd_data [READ_PORTS];
  logic [READ_PORTS-1:0]  rd_busy;

  logic                   rsv_en;
  logic [ID_LENGTH-1:0]   rsv_id;
  logic                   rsv_ack;
  logic [CNT_W-1:0]       busy_count;

  modport master (
    output wr_en, wr_id, wr_data, rd_id, rsv_en, rsv_id,
    input  rd_data, rd_busy, rsv_ack, busy_count
  );

  modport slave (
    input  wr_en, wr_id, wr_data, rd_id, rsv_en, rsv_id,
    output rd_data, rd_busy, rsv_ack, busy_count
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reservation acknowledge, busy vector and busy count.
// A write releases its register; a reservation in the same cycle on the same id wins.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int ID_LENGTH = DEF_ID_LENGTH,
  parameter  int NUM_REGS  = 2**ID_LENGTH,
  localparam int CNT_W     = $clog2(NUM_REGS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_i,
  input  logic [ID_LENGTH-1:0] wr_id_i,
  input  logic                 rsv_en_i,
  input  logic [ID_LENGTH-1:0] rsv_id_i,
  output logic [NUM_REGS-1:0]  busy_o,
  output logic                 rsv_ack_o,
  output logic [CNT_W-1:0]     busy_count_o
);

  localparam int DEPTH = 2**ID_LENGTH;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DEPTH-1:0]    busy_ext;
  logic                wr_hit;
  logic                rsv_valid;
  logic                rsv_set;

  // Unimplemented ids read as never busy.
  assign busy_ext = DEPTH'(busy_q);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path infers a latch.
    busy_d    = busy_q;
    count_d   = '0;
    wr_hit    = wr_en_i && id_writable(int'(wr_id_i), NUM_REGS);
    rsv_valid = rsv_en_i && id_in_range(int'(rsv_id_i), NUM_REGS);
    rsv_ack_o = rsv_valid && (!busy_ext[rsv_id_i] || (wr_en_i && wr_id_i == rsv_id_i));
    rsv_set   = rsv_ack_o && id_writable(int'(rsv_id_i), NUM_REGS);

    for (int r = 0; r < NUM_REGS; r++) begin
      if (wr_hit && wr_id_i == ID_LENGTH'(r)) busy_d[r] = 1'b0;
      if (rsv_set && rsv_id_i == ID_LENGTH'(r)) busy_d[r] = 1'b1;
    end

    // Counting the next vector keeps the count exact and bounded to 0..NUM_REGS.
    for (int r = 0; r < NUM_REGS; r++) begin
      count_d = count_d + CNT_W'(busy_d[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o       = busy_q;
  assign busy_count_o = count_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-first bypass and busy scoreboard.
// Storage and read muxes live here; reservation tracking is in regfile_scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int ID_LENGTH   = DEF_ID_LENGTH,
  parameter int NUM_REGS    = 2**ID_LENGTH,
  parameter int READ_PORTS  = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 2**ID_LENGTH;

  logic [WORD_LENGTH-1:0] mem_q [NUM_REGS];
  logic [NUM_REGS-1:0]    busy;
  logic [DEPTH-1:0]       busy_ext;
  logic                   wr_ok;

  assign wr_ok    = bus.wr_en && id_writable(int'(bus.wr_id), NUM_REGS);
  assign busy_ext = DEPTH'(busy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the array is reset explicitly; operands must read as zero after reset.
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_ok && bus.wr_id == ID_LENGTH'(r)) mem_q[r] <= bus.wr_data;
      end
    end
  end

  regfile_scoreboard #(
    .ID_LENGTH (ID_LENGTH),
    .NUM_REGS  (NUM_REGS)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (bus.wr_en),
    .wr_id_i      (bus.wr_id),
    .rsv_en_i     (bus.rsv_en),
    .rsv_id_i     (bus.rsv_id),
    .busy_o       (busy),
    .rsv_ack_o    (bus.rsv_ack),
    .busy_count_o (bus.busy_count)
  );

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
    logic readable;
    logic hit;

    // A readable id that matches the writeback takes the incoming data and is not busy.
    assign readable = id_writable(int'(bus.rd_id[i]), NUM_REGS);
    assign hit      = bus.wr_en && bus.wr_id == bus.rd_id[i];

    assign bus.rd_data[i] = !readable ? '0 :
                            hit       ? bus.wr_data : mem_q[bus.rd_id[i]];
    assign bus.rd_busy[i] = readable && busy_ext[bus.rd_id[i]] && !hit;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: reference model feeds an expectation queue,
// plus directed checks of bypass, reservation, range limits and the zero register.
module tb_regfile_mp;

  localparam int WL = 16;
  localparam int IL = 3;
  localparam int NR = 8;
  localparam int RP = 2;

`ifdef ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.WORD_LENGTH(WL), .ID_LENGTH(IL), .NUM_REGS(NR), .READ_PORTS(RP)) bus ();
  regfile_mp_if #(.WORD_LENGTH(WL), .ID_LENGTH(IL), .NUM_REGS(6),  .READ_PORTS(RP)) bus6 ();

  regfile_mp #(.WORD_LENGTH(WL), .ID_LENGTH(IL), .NUM_REGS(NR), .READ_PORTS(RP)) u_dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );

  regfile_mp #(.WORD_LENGTH(WL), .ID_LENGTH(IL), .NUM_REGS(6), .READ_PORTS(RP)) u_dut6 (
    .clk (clk), .rst (rst), .bus (bus6.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  // Reference model of the 8-register instance
  logic [15:0] m_mem [NR];
  logic [7:0]  m_busy;
  int          m_cnt;

  task automatic m_reset();
    for (int r = 0; r < NR; r++) m_mem[r] = '0;
    m_busy = '0;
    m_cnt  = 0;
  endtask

  function automatic logic [15:0] m_read(input logic [2:0] id);
    if (ZERO && id == 3'd0) return '0;
    if (bus.wr_en && bus.wr_id == id) return bus.wr_data;
    return m_mem[id];
  endfunction

  function automatic logic m_rbusy(input logic [2:0] id);
    if (ZERO && id == 3'd0) return 1'b0;
    return m_busy[id] && !(bus.wr_en && bus.wr_id == id);
  endfunction

  function automatic logic m_ack();
    return bus.rsv_en && (!m_busy[bus.rsv_id] || (bus.wr_en && bus.wr_id == bus.rsv_id));
  endfunction

  task automatic set_inputs(input logic we, input logic [2:0] wid, input logic [15:0] wd,
                            input logic [2:0] r0, input logic [2:0] r1,
                            input logic re, input logic [2:0] rid);
    bus.wr_en  = we;  bus.wr_id  = wid; bus.wr_data  = wd;
    bus.rd_id[0] = r0; bus.rd_id[1] = r1;
    bus.rsv_en = re;  bus.rsv_id = rid;
    bus6.wr_en = we;  bus6.wr_id = wid; bus6.wr_data = wd;
    bus6.rd_id[0] = r0; bus6.rd_id[1] = r1;
    bus6.rsv_en = re; bus6.rsv_id = rid;
  endtask

  task automatic compare_outputs();
    logic [31:0] obs [6];
    exp_t        e;
    obs[0] = 32'(bus.rd_data[0]);
    obs[1] = 32'(bus.rd_data[1]);
    obs[2] = 32'(bus.rd_busy[0]);
    obs[3] = 32'(bus.rd_busy[1]);
    obs[4] = 32'(bus.rsv_ack);
    obs[5] = 32'(bus.busy_count);
    for (int k = 0; k < 6; k++) begin
      if (exp_q.size() == 0) begin
        check("queue_underflow", 32'(k), 32'(6));
      end else begin
        e = exp_q.pop_front();
        check(e.tag, obs[k], e.val);
      end
    end
  endtask

  // Drive on the falling edge, queue the model's view, compare once outputs settle.
  task automatic apply(input logic we, input logic [2:0] wid, input logic [15:0] wd,
                       input logic [2:0] r0, input logic [2:0] r1,
                       input logic re, input logic [2:0] rid);
    @(negedge clk);
    set_inputs(we, wid, wd, r0, r1, re, rid);
    exp_q.push_back('{tag: "rd_data0",   val: 32'(m_read(r0))});
    exp_q.push_back('{tag: "rd_data1",   val: 32'(m_read(r1))});
    exp_q.push_back('{tag: "rd_busy0",   val: 32'(m_rbusy(r0))});
    exp_q.push_back('{tag: "rd_busy1",   val: 32'(m_rbusy(r1))});
    exp_q.push_back('{tag: "rsv_ack",    val: 32'(m_ack())});
    exp_q.push_back('{tag: "busy_count", val: 32'(m_cnt)});
    #1;
    compare_outputs();
  endtask

  task automatic commit();
    logic ack, wv, sv, bw, br;
    @(posedge clk);
    ack = m_ack();
    wv  = bus.wr_en && !(ZERO && bus.wr_id == 3'd0);
    sv  = ack && !(ZERO && bus.rsv_id == 3'd0);
    bw  = m_busy[bus.wr_id];
    br  = m_busy[bus.rsv_id];
    if (sv && !br) m_cnt++;
    if (wv && bw && !(sv && bus.rsv_id == bus.wr_id)) m_cnt--;
    if (wv) begin
      m_mem[bus.wr_id]  = bus.wr_data;
      m_busy[bus.wr_id] = 1'b0;
    end
    if (sv) m_busy[bus.rsv_id] = 1'b1;
  endtask

  task automatic idle_cycle(input logic [2:0] r0, input logic [2:0] r1);
    apply(1'b0, 3'd0, 16'h0, r0, r1, 1'b0, 3'd0);
    commit();
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: bench did not complete");
  end

  initial begin
    rst = 1'b1;
    set_inputs(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0);
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    idle_cycle(3'd0, 3'd7);
    check("reset_count", 32'(bus.busy_count), 32'd0);

    // Traffic, then an asynchronous reset in the middle of a cycle
    apply(1'b1, 3'd1, 16'hAAAA, 3'd1, 3'd4, 1'b1, 3'd4); commit();
    apply(1'b1, 3'd7, 16'h5555, 3'd7, 3'd6, 1'b1, 3'd6); commit();
    apply(1'b1, 3'd1, 16'h1111, 3'd1, 3'd5, 1'b1, 3'd5);
    #2 rst = 1'b1;
    m_reset();
    @(negedge clk);
    set_inputs(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0);
    rst = 1'b0;
    for (int id = 0; id < NR; id += 2) begin
      apply(1'b0, 3'd0, 16'h0, 3'(id), 3'(id + 1), 1'b0, 3'd0);
      check("t1_data0", 32'(bus.rd_data[0]), 32'h0);
      check("t1_data1", 32'(bus.rd_data[1]), 32'h0);
      commit();
    end
    check("t1_count", 32'(bus.busy_count), 32'd0);

    // Write-first bypass on both ports
    apply(1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd5, 1'b0, 3'd0);
    check("t2_bypass0", 32'(bus.rd_data[0]), 32'hBEEF);
    check("t2_bypass1", 32'(bus.rd_data[1]), 32'hBEEF);
    commit();
    apply(1'b0, 3'd0, 16'h0, 3'd5, 3'd5, 1'b0, 3'd0);
    check("t2_stored", 32'(bus.rd_data[1]), 32'hBEEF);
    commit();

    // Reserve, retry on busy, release by writeback
    apply(1'b0, 3'd0, 16'h0, 3'd3, 3'd3, 1'b1, 3'd3);
    check("t3_ack1", 32'(bus.rsv_ack), 32'd1);
    commit();
    apply(1'b0, 3'd0, 16'h0, 3'd3, 3'd2, 1'b1, 3'd3);
    check("t3_ack2", 32'(bus.rsv_ack), 32'd0);
    check("t3_count1", 32'(bus.busy_count), 32'd1);
    check("t3_busy", 32'(bus.rd_busy[0]), 32'd1);
    commit();
    apply(1'b1, 3'd3, 16'h1234, 3'd3, 3'd3, 1'b0, 3'd0);
    check("t3_bypass_busy", 32'(bus.rd_busy[0]), 32'd0);
    commit();
    apply(1'b0, 3'd0, 16'h0, 3'd3, 3'd5, 1'b0, 3'd0);
    check("t3_count0", 32'(bus.busy_count), 32'd0);
    check("t3_data", 32'(bus.rd_data[0]), 32'h1234);
    commit();

    // Same-cycle write and reserve of a busy register
    apply(1'b0, 3'd0, 16'h0, 3'd2, 3'd2, 1'b1, 3'd2); commit();
    apply(1'b1, 3'd2, 16'h0042, 3'd2, 3'd1, 1'b1, 3'd2);
    check("t4_ack", 32'(bus.rsv_ack), 32'd1);
    commit();
    apply(1'b0, 3'd0, 16'h0, 3'd2, 3'd2, 1'b0, 3'd0);
    check("t4_data", 32'(bus.rd_data[0]), 32'h0042);
    check("t4_busy", 32'(bus.rd_busy[1]), 32'd1);
    check("t4_count", 32'(bus.busy_count), 32'd1);
    commit();
    apply(1'b1, 3'd2, 16'h0043, 3'd2, 3'd0, 1'b0, 3'd0); commit();

    // Fill the scoreboard, retry when full, then drain
    for (int r = 0; r < NR; r++) begin
      apply(1'b0, 3'd0, 16'h0, 3'(r), 3'd7, 1'b1, 3'(r));
      commit();
    end
    apply(1'b0, 3'd0, 16'h0, 3'd7, 3'd4, 1'b1, 3'd5);
    check("full_count", 32'(bus.busy_count), ZERO ? 32'd7 : 32'd8);
    check("full_ack", 32'(bus.rsv_ack), 32'd0);
    commit();
    for (int r = 0; r < NR; r++) begin
      apply(1'b1, 3'(r), 16'(r * 16'h1111), 3'(r), 3'd6, 1'b0, 3'd0);
      commit();
    end
    idle_cycle(3'd6, 3'd4);
    check("drain_count", 32'(bus.busy_count), 32'd0);

    // Range limits on the 6-register instance
    apply(1'b1, 3'd7, 16'h7777, 3'd7, 3'd6, 1'b0, 3'd0);
    check("t5_rd7", 32'(bus6.rd_data[0]), 32'h0);
    check("t5_rd6", 32'(bus6.rd_data[1]), 32'h0);
    commit();
    apply(1'b1, 3'd5, 16'h5A5A, 3'd7, 3'd6, 1'b1, 3'd6);
    check("t5_rsv6_ack", 32'(bus6.rsv_ack), 32'd0);
    check("t5_rd6_busy", 32'(bus6.rd_busy[1]), 32'd0);
    commit();
    apply(1'b0, 3'd0, 16'h0, 3'd5, 3'd7, 1'b0, 3'd0);
    check("t5_rd5", 32'(bus6.rd_data[0]), 32'h5A5A);
    check("t5_rd7_after", 32'(bus6.rd_data[1]), 32'h0);
    check("t5_count", 32'(bus6.busy_count), 32'd0);
    commit();

    // Register 0: hardwired or ordinary depending on the build
    apply(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1'b0, 3'd0); commit();
    apply(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0);
    check("t6_r0", 32'(bus.rd_data[0]), ZERO ? 32'h0 : 32'hFFFF);
    commit();
    apply(1'b0, 3'd0, 16'h0, 3'd0, 3'd1, 1'b1, 3'd0);
    check("t6_ack", 32'(bus.rsv_ack), 32'd1);
    commit();
    apply(1'b0, 3'd0, 16'h0, 3'd0, 3'd1, 1'b0, 3'd0);
    check("t6_busy", 32'(bus.rd_busy[0]), ZERO ? 32'd0 : 32'd1);
    commit();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
